bit_stream_packer: RTL and testbench

- Downstream consumer of the enable-gated D flip-flop stage.
- Collects its serial output bit `q`, qualified by a valid strobe and the 5-bit enable code in force, into WIDTH-bit words.
- Each word is tagged with its enable code and bit count.
- Words leave through a small FIFO with valid/ready handshake toward the bus/CSR side.
- A change of enable code mid-word closes the partial word, so one word never mixes codes.

---
 rtl/bit_stream_packer_pkg.sv | 31 +++
 rtl/bit_stream_packer_if.sv | 16 +
 rtl/bit_stream_packer_fifo.sv | 64 ++++++
 rtl/bit_stream_packer.sv | 173 +++++++++++++++++
 tb/tb_bit_stream_packer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bit_stream_packer_pkg.sv
// Shared types and constants for the bit stream packer:
// FSM state encoding, the FIFO word record and a bit-mask helper.
package bit_pack_pkg;

   localparam int TAG_W_DEFAULT = 5;
   localparam int MAX_WIDTH     = 32;
   localparam int MAX_CNT_W     = 6;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   // Sized for the largest legal word; the packer uses the low bits of each field.
   typedef struct packed {
      logic [MAX_WIDTH-1:0]     data;
      logic [TAG_W_DEFAULT-1:0] tag;
      logic [MAX_CNT_W-1:0]     cnt;
   } word_t;

   // Ones in positions below n, zeros at and above n.
   function automatic logic [MAX_WIDTH-1:0] low_mask(input logic [MAX_CNT_W-1:0] n);
      logic [MAX_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         m[i] = (i < int'(n));
      end
      return m;
   endfunction

endpackage

// File: rtl/bit_stream_packer_if.sv
// Output word bus of the packer: head-of-FIFO word with valid/ready handshake.
interface bit_stream_packer_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 5
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] word_out;
   logic [TAG_W-1:0] word_tag;
   logic [CNT_W-1:0] word_cnt;
   logic             word_vld;
   logic             word_rdy;

   modport master (output word_out, word_tag, word_cnt, word_vld, input word_rdy);
   modport slave  (input word_out, word_tag, word_cnt, word_vld, output word_rdy);
endinterface

// File: rtl/bit_stream_packer_fifo.sv
// Small shift-style FIFO of packed words. Entry 0 is the head and is read
// straight from its flops; entries at or above the fill count are kept zero,
// so the head reads all-zero whenever the FIFO is empty.
module pack_fifo
   import bit_pack_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  push,
   input  word_t din,
   input  logic  pop,
   output word_t head,
   output logic  full,
   output logic  empty
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   word_t            ent_r [DEPTH];
   logic [CNT_W-1:0] count_r;
   logic             pop_ok_s;
   logic             push_ok_s;
   logic [CNT_W-1:0] wr_idx_s;

   // Flag decode and write-slot selection; a pop frees a slot for a same-cycle push.
   always_comb begin
      full      = (count_r == CNT_W'(DEPTH));
      empty     = (count_r == '0);
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
      if (pop_ok_s) begin
         wr_idx_s = count_r - CNT_W'(1);
      end else begin
         wr_idx_s = count_r;
      end
   end

   // Storage shift on pop, write at the first free slot on push, fill count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_r[i] <= '0;
         end
         count_r <= '0;
      end else begin
         if (pop_ok_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               ent_r[i] <= ent_r[i+1];
            end
            ent_r[DEPTH-1] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (push_ok_s && (wr_idx_s == CNT_W'(i))) begin
               ent_r[i] <= din;
            end
         end
         count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      end
   end

   assign head = ent_r[0];

endmodule

// File: rtl/bit_stream_packer.sv
// Packs a qualified serial bit stream into tagged words. A word closes when it
// is full, on flush, or when the enable code changes; closed words go out
// through a small FIFO. Flush together with a tag change closes two words, the
// second one a cycle later through a pending-flush flag.
module bit_stream_packer
   import bit_pack_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 2,
   parameter int TAG_W      = TAG_W_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                bit_in,
   input  logic                bit_vld,
   input  logic [TAG_W-1:0]    tag_in,
   input  logic                flush,
   input  logic                clr_ovf,
   bit_stream_packer_if.master wb,
   output logic                tag_change,
   output logic                overflow
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e           state_r;
   logic [WIDTH-1:0] shreg_r;
   logic [CNT_W-1:0] cnt_r;
   logic [TAG_W-1:0] cur_tag_r;
   logic             pend_flush_r;
   logic             tag_change_r;
   logic             overflow_r;

   logic             flush_eff_s;
   logic             tag_match_s;
   logic             close_s;
   logic [WIDTH-1:0] ins_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             push_s;
   word_t            push_word_s;
   word_t            head_s;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             drop_s;
   logic             unused_head_s;

   function automatic word_t make_word(input logic [WIDTH-1:0] d,
                                       input logic [TAG_W-1:0] t,
                                       input logic [CNT_W-1:0] c);
      word_t w;
      w.data = MAX_WIDTH'(d) & low_mask(MAX_CNT_W'(c));
      w.tag  = TAG_W_DEFAULT'(t);
      w.cnt  = MAX_CNT_W'(c);
      return w;
   endfunction

   // Append position, close conditions and the word offered to the FIFO this cycle.
   always_comb begin
      flush_eff_s = flush | pend_flush_r;
      tag_match_s = (tag_in == cur_tag_r);
      cnt_inc_s   = cnt_r + CNT_W'(1);
      close_s     = (cnt_inc_s == CNT_W'(WIDTH)) | flush_eff_s;
      for (int i = 0; i < WIDTH; i++) begin
         ins_s[i] = (i == int'(cnt_r)) ? bit_in : shreg_r[i];
      end
      push_s      = 1'b0;
      push_word_s = '0;
      if (state_r == FILL) begin
         if (bit_vld && tag_match_s) begin
            if (close_s) begin
               push_s      = 1'b1;
               push_word_s = make_word(ins_s, cur_tag_r, cnt_inc_s);
            end else begin
               push_s = 1'b0;
            end
         end else if (bit_vld || flush_eff_s) begin
            push_s      = 1'b1;
            push_word_s = make_word(shreg_r, cur_tag_r, cnt_r);
         end else begin
            push_s = 1'b0;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // Packer FSM: shift register, bit count, current tag and the tag-change pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         shreg_r      <= '0;
         cnt_r        <= '0;
         cur_tag_r    <= '0;
         pend_flush_r <= 1'b0;
         tag_change_r <= 1'b0;
      end else begin
         tag_change_r <= 1'b0;
         pend_flush_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bit_vld) begin
                  shreg_r   <= WIDTH'(bit_in);
                  cnt_r     <= CNT_W'(1);
                  cur_tag_r <= tag_in;
                  state_r   <= FILL;
               end
            end
            FILL: begin
               if (bit_vld && tag_match_s) begin
                  if (close_s) begin
                     shreg_r <= '0;
                     cnt_r   <= '0;
                     state_r <= IDLE;
                  end else begin
                     shreg_r <= ins_s;
                     cnt_r   <= cnt_inc_s;
                  end
               end else if (bit_vld) begin
                  // Old word leaves this cycle; the new bit opens a fresh word.
                  shreg_r      <= WIDTH'(bit_in);
                  cnt_r        <= CNT_W'(1);
                  cur_tag_r    <= tag_in;
                  tag_change_r <= 1'b1;
                  pend_flush_r <= flush;
               end else if (flush_eff_s) begin
                  shreg_r <= '0;
                  cnt_r   <= '0;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Sticky overflow: a drop sets it and wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_ovf) begin
         overflow_r <= 1'b0;
      end
   end

   pack_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .din     (push_word_s),
      .pop     (pop_s),
      .head    (head_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   assign pop_s         = ~empty_s & wb.word_rdy;
   assign drop_s        = push_s & full_s & ~pop_s;
   assign unused_head_s = ^head_s;

   assign wb.word_out = head_s.data[WIDTH-1:0];
   assign wb.word_tag = head_s.tag[TAG_W-1:0];
   assign wb.word_cnt = head_s.cnt[CNT_W-1:0];
   assign wb.word_vld = ~empty_s;
   assign tag_change  = tag_change_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer with a scoreboard: expected words are
// queued when stimulus is issued and a negedge monitor checks each handshake.
module tb_bit_stream_packer;

   typedef struct packed {
      logic [7:0] d;
      logic [4:0] t;
      logic [3:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_vld = 1'b0;
   logic [4:0] tag_in = 5'd0;
   logic       flush = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       tag_change;
   logic       overflow;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   bit_stream_packer_if #(.WIDTH(8), .TAG_W(5)) bus ();

   bit_stream_packer #(.WIDTH(8), .FIFO_DEPTH(2), .TAG_W(5)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bit_in     (bit_in),
      .bit_vld    (bit_vld),
      .tag_in     (tag_in),
      .flush      (flush),
      .clr_ovf    (clr_ovf),
      .wb         (bus),
      .tag_change (tag_change),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head word is compared with the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && bus.word_vld && bus.word_rdy) begin
         if (sb.size() == 0) begin
            check("unexpected_word", 32'({bus.word_out, bus.word_tag, bus.word_cnt}), 32'hFFFF_FFFF);
         end else begin
            check("word", 32'({bus.word_out, bus.word_tag, bus.word_cnt}), 32'(sb.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic [4:0] t, input logic f);
      bit_in  = b;
      bit_vld = 1'b1;
      tag_in  = t;
      flush   = f;
      tick();
      bit_vld = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d, input logic [4:0] t);
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i], t, 1'b0);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         tick();
      end
      tick();
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] w1;
      bus.word_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();

      // Reset state
      check("rst_vld", 32'(bus.word_vld), 32'd0);
      check("rst_out", 32'(bus.word_out), 32'd0);
      check("rst_tag", 32'(bus.word_tag), 32'd0);
      check("rst_cnt", 32'(bus.word_cnt), 32'd0);
      check("rst_tchg", 32'(tag_change), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // 1: one full word, LSB first
      bus.word_rdy = 1'b1;
      w1 = 8'b0100_1101;
      sb.push_back('{d: 8'h4D, t: 5'h1F, c: 4'd8});
      for (int i = 0; i < 7; i++) begin
         send_bit(w1[i], 5'h1F, 1'b0);
      end
      check("t1_vld_early", 32'(bus.word_vld), 32'd0);
      send_bit(w1[7], 5'h1F, 1'b0);
      check("t1_vld_latency", 32'(bus.word_vld), 32'd1);
      wait_drain("t1_drain");

      // 2: tag change closes a partial word, flush closes the next
      sb.push_back('{d: 8'h03, t: 5'h1F, c: 4'd3});
      sb.push_back('{d: 8'h01, t: 5'h1E, c: 4'd1});
      send_bit(1'b1, 5'h1F, 1'b0);
      send_bit(1'b1, 5'h1F, 1'b0);
      send_bit(1'b0, 5'h1F, 1'b0);
      send_bit(1'b1, 5'h1E, 1'b0);
      check("t2_tchg_pulse", 32'(tag_change), 32'd1);
      tick();
      check("t2_tchg_clear", 32'(tag_change), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_drain("t2_drain");

      // 3: overflow on a third word into a full FIFO
      bus.word_rdy = 1'b0;
      sb.push_back('{d: 8'hA5, t: 5'h03, c: 4'd8});
      sb.push_back('{d: 8'h3C, t: 5'h04, c: 4'd8});
      send_word(8'hA5, 5'h03);
      send_word(8'h3C, 5'h04);
      check("t3_no_ovf_yet", 32'(overflow), 32'd0);
      send_word(8'hFF, 5'h06);
      check("t3_ovf_set", 32'(overflow), 32'd1);
      check("t3_head_stable", 32'({bus.word_out, bus.word_tag}), 32'({8'hA5, 5'h03}));
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t3_ovf_clr", 32'(overflow), 32'd0);
      bus.word_rdy = 1'b1;
      wait_drain("t3_drain");

      // 4: push and pop in the same cycle while full
      bus.word_rdy = 1'b0;
      sb.push_back('{d: 8'h11, t: 5'h01, c: 4'd8});
      sb.push_back('{d: 8'h22, t: 5'h02, c: 4'd8});
      sb.push_back('{d: 8'h33, t: 5'h07, c: 4'd8});
      send_word(8'h11, 5'h01);
      send_word(8'h22, 5'h02);
      w1 = 8'h33;
      for (int i = 0; i < 7; i++) begin
         send_bit(w1[i], 5'h07, 1'b0);
      end
      bus.word_rdy = 1'b1;
      send_bit(w1[7], 5'h07, 1'b0);
      bus.word_rdy = 1'b0;
      check("t4_no_ovf", 32'(overflow), 32'd0);
      check("t4_head_adv", 32'(bus.word_out), 32'h22);
      check("t4_vld", 32'(bus.word_vld), 32'd1);
      bus.word_rdy = 1'b1;
      wait_drain("t4_drain");

      // 5: flush with a tag-change bit gives two pushes on consecutive cycles
      sb.push_back('{d: 8'h02, t: 5'h02, c: 4'd2});
      sb.push_back('{d: 8'h01, t: 5'h09, c: 4'd1});
      send_bit(1'b0, 5'h02, 1'b0);
      send_bit(1'b1, 5'h02, 1'b0);
      send_bit(1'b1, 5'h09, 1'b1);
      check("t5_tchg", 32'(tag_change), 32'd1);
      check("t5_first_vld", 32'(bus.word_vld), 32'd1);
      tick();
      check("t5_second_cnt", 32'({bus.word_vld, bus.word_cnt}), 32'({1'b1, 4'd1}));
      check("t5_idle", 32'(dut.state_r), 32'd0);
      wait_drain("t5_drain");

      // 6: asynchronous reset mid-word with a non-empty FIFO
      bus.word_rdy = 1'b0;
      sb.push_back('{d: 8'h5A, t: 5'h03, c: 4'd8});
      send_word(8'h5A, 5'h03);
      send_bit(1'b1, 5'h03, 1'b0);
      send_bit(1'b1, 5'h03, 1'b0);
      send_bit(1'b1, 5'h03, 1'b0);
      check("t6_vld_before", 32'(bus.word_vld), 32'd1);
      reset_n = 1'b0;
      #1;
      check("t6_vld_async", 32'(bus.word_vld), 32'd0);
      check("t6_out_async", 32'(bus.word_out), 32'd0);
      sb.delete();
      tick();
      reset_n = 1'b1;
      tick();
      bus.word_rdy = 1'b1;
      sb.push_back('{d: 8'hC3, t: 5'h04, c: 4'd8});
      send_word(8'hC3, 5'h04);
      wait_drain("t6_drain");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
